// File: rtl/rr_encoder_demux.sv
// rr_encoder_demux: round-robin encodes synchronized requests and demuxes a data bit
// into a per-channel holding register, holding the grant for a fixed time.
module rr_encoder_demux #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       din,
   output logic       grant_valid,
   output logic [1:0] grant_idx,
   output logic [3:0] grant_onehot,
   output logic [3:0] q,
   output logic       busy
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
   state_t state_q, state_d;
   logic [4:0] sync_q [SYNC_STAGES];
   logic [3:0] req_s, rot, q_q;
   logic din_s, hit;
   logic [1:0] ptr_q, idx_q, win;
   logic [CW-1:0] cnt_q;
   // req and din share one pipeline so they stay aligned
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {din, req};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
   assign {din_s, req_s} = sync_q[SYNC_STAGES-1];
   // rotate so bit 0 is the ptr channel; lowest set bit of the rotation wins
   always_comb begin
      rot = 4'({req_s, req_s} >> ptr_q);
      hit = |req_s;
      win = ptr_q;
      for (int k = 3; k >= 0; k--) if (rot[k]) win = ptr_q + 2'(k);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (hit ? WRITE : IDLE) :
                (state_q == WRITE) ? HOLD : ((cnt_q == '0) ? IDLE : HOLD);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         q_q   <= '0;
      end else begin
         case (state_q)
            IDLE:  if (hit) idx_q <= win;
            WRITE: begin
               q_q[idx_q] <= din_s;
               cnt_q      <= CW'(HOLD_CYCLES - 1);
            end
            HOLD:  if (cnt_q == '0) begin
               ptr_q <= idx_q + 2'd1;
               idx_q <= '0;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      grant_valid  = state_q != IDLE;
      busy         = grant_valid;
      grant_idx    = idx_q;
      grant_onehot = grant_valid ? 4'b0001 << idx_q : 4'b0000;
      q            = q_q;
   end
endmodule

// File: tb/tb_rr_encoder_demux.sv
// tb_rr_encoder_demux: directed and random stimulus checked against a cycle-count
// reference model of the round-robin grant/demux behaviour.
module tb_rr_encoder_demux;
   localparam int S = 2;
   localparam int H = 4;
   logic clock = 0, reset = 1, din = 0;
   logic [3:0] req = 0;
   logic grant_valid, busy;
   logic [1:0] grant_idx;
   logic [3:0] grant_onehot, q;
   int ncmp = 0, nerr = 0;
   logic [4:0] m_pipe [S];
   int m_rem, m_ptr, m_idx;
   logic [3:0] m_q;
   logic prev_v;
   int grants [$];

   rr_encoder_demux #(.SYNC_STAGES(S), .HOLD_CYCLES(H)) dut (
      .clock(clock), .reset(reset), .req(req), .din(din),
      .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
      .q(q), .busy(busy));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < S; i++) m_pipe[i] = '0;
      m_rem = 0; m_ptr = 0; m_idx = 0; m_q = 0; prev_v = 0;
   endtask

   // one clock edge: a grant lasts 1+H cycles, q written on its first cycle
   task automatic model_edge(input logic [3:0] r, input logic d);
      logic [3:0] rs;
      logic ds;
      bit found;
      rs = m_pipe[S-1][3:0];
      ds = m_pipe[S-1][4];
      if (m_rem == 0) begin
         found = 0;
         for (int k = 0; k < 4; k++)
            if (!found && rs[(m_ptr + k) % 4]) begin
               found = 1;
               m_idx = (m_ptr + k) % 4;
            end
         if (found) m_rem = 1 + H;
      end else begin
         if (m_rem == 1 + H) m_q[m_idx] = ds;
         m_rem--;
         if (m_rem == 0) begin
            m_ptr = (m_idx + 1) % 4;
            m_idx = 0;
         end
      end
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = {d, r};
   endtask

   task automatic check_model();
      logic v;
      v = m_rem > 0;
      chk("valid", 8'(grant_valid), 8'(v));
      chk("busy", 8'(busy), 8'(v));
      chk("idx", 8'(grant_idx), 8'(m_idx));
      chk("onehot", 8'(grant_onehot), v ? 8'(1 << m_idx) : 8'h0);
      chk("q", 8'(q), 8'(m_q));
   endtask

   task automatic tick(input logic [3:0] r, input logic d);
      @(negedge clock);
      req = r;
      din = d;
      @(posedge clock);
      model_edge(r, d);
      #1;
      check_model();
      if (grant_valid && !prev_v) grants.push_back(int'(grant_idx));
      prev_v = grant_valid;
   endtask

   // entered and left at posedge+1; reset asserted between edges
   task automatic do_reset();
      #2 reset = 1;
      #1 model_reset();
      check_model();
      @(posedge clock);
      #1 reset = 0;
      grants.delete();
   endtask

   task automatic grant_ch(input int ch, input logic d);
      for (int i = 0; i < 3; i++) tick(4'(1 << ch), d);
      for (int i = 0; i < 6; i++) tick(4'b0000, d);
   endtask

   initial begin
      model_reset();
      @(posedge clock);
      #1 check_model();
      reset = 0;
      // T1: reset mid-HOLD with q=1010
      grant_ch(1, 1);
      grant_ch(3, 1);
      tick(4'b0001, 0); tick(4'b0001, 0); tick(4'b0000, 0);
      tick(4'b0000, 0); tick(4'b0000, 0);
      chk("t1_q_before", 8'(q), 8'b1010);
      chk("t1_hold", 8'(grant_valid), 8'd1);
      do_reset();
      chk("t1_q_after", 8'(q), 8'd0);
      for (int i = 0; i < 4; i++) tick(4'b1111, 0);
      chk("t1_first", grants.size() > 0 ? 8'(grants[0]) : 8'hff, 8'd0);
      // T2: single request latency and duration
      do_reset();
      tick(4'b0100, 1); tick(4'b0100, 1);
      chk("t2_pre", 8'(grant_valid), 8'd0);
      tick(4'b0100, 1);
      chk("t2_rise", 8'(grant_valid), 8'd1);
      chk("t2_idx", 8'(grant_idx), 8'd2);
      chk("t2_oh", 8'(grant_onehot), 8'b0100);
      tick(4'b0000, 1);
      chk("t2_q", 8'(q), 8'b0100);
      for (int i = 0; i < 3; i++) tick(4'b0000, 1);
      chk("t2_last", 8'(grant_valid), 8'd1);
      tick(4'b0000, 1);
      chk("t2_end", 8'(grant_valid), 8'd0);
      // T3: round robin
      do_reset();
      for (int i = 0; i < 30; i++) tick(4'b1111, 0);
      chk("t3_n", 8'(grants.size()), 8'd5);
      for (int i = 0; i < 5 && i < grants.size(); i++) chk("t3_seq", 8'(grants[i]), 8'(i % 4));
      // T4: priority search from ptr
      do_reset();
      for (int i = 0; i < 5; i++) tick(4'b0010, 0);
      for (int i = 0; i < 20; i++) tick(4'b0011, 0);
      chk("t4_n", 8'(grants.size() >= 3), 8'd1);
      if (grants.size() >= 3) begin
         chk("t4_g0", 8'(grants[0]), 8'd1);
         chk("t4_g1", 8'(grants[1]), 8'd0);
         chk("t4_g2", 8'(grants[2]), 8'd1);
      end
      // T5: demux isolation
      do_reset();
      for (int c = 0; c < 4; c++) grant_ch(c, 1);
      chk("t5_full", 8'(q), 8'b1111);
      for (int i = 0; i < 3; i++) tick(4'b0100, 0);
      for (int i = 0; i < 6; i++) tick(4'b0000, i[0]);
      chk("t5_q", 8'(q), 8'b1011);
      // T6: early release; short pulse during HOLD ignored
      do_reset();
      for (int i = 0; i < 4; i++) tick(4'b0001, 0);
      tick(4'b0000, 0);
      tick(4'b0001, 0);
      for (int i = 0; i < 10; i++) tick(4'b0000, 0);
      chk("t6_n", 8'(grants.size()), 8'd1);
      // random stimulus with occasional async reset
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         tick(4'($urandom) & 4'($urandom), 1'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
